// File: rtl/load_align_sequencer.sv
// load_align_sequencer: sequences data-memory reads for loads.
// A load that straddles an aligned BYTES boundary is fetched as two aligned
// beats. The beats are merged, the addressed bytes are selected, and the
// value is sign- or zero-extended to BIT_COUNT bits.
//
// Handshake: mem_req is raised with a stable mem_addr and held until a cycle
// in which mem_ack is high at the rising edge; that edge transfers mem_rdata.
// mem_ack is ignored whenever mem_req is low. ld_valid is sampled only in IDLE.
module load_align_sequencer #(
  parameter int BIT_COUNT = 32,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_valid,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [2:0]           ld_mode,
  output logic                 busy,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_ack,
  input  logic [BIT_COUNT-1:0] mem_rdata,
  output logic                 ld_done,
  output logic [BIT_COUNT-1:0] ld_result,
  output logic                 ld_fault,
  output logic [1:0]           dbg_state
);

  localparam int BYTES = BIT_COUNT / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int IW    = $clog2(BIT_COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT1 = 2'd1,
    S_BEAT2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_W-1:0]    r_mem_addr;
  logic [OFS-1:0]       r_ofs;
  logic [3:0]           r_size;
  logic                 r_signed;
  logic                 r_split;
  logic [BIT_COUNT-1:0] r_lo;
  logic [BIT_COUNT-1:0] r_result;
  logic                 r_fault;

  logic [3:0]             w_size;
  logic                   w_legal;
  logic                   w_signed;
  logic [4:0]             w_span;
  logic                   w_split;
  logic                   w_accept;
  logic                   w_fault;
  logic                   w_cap_lo;
  logic                   w_to_beat2;
  logic                   w_to_done;
  logic [2*BIT_COUNT-1:0] w_merged;
  logic [BIT_COUNT-1:0]   w_raw;
  logic [BIT_COUNT-1:0]   w_result;

  // Keep the low 8*size bits of raw; fill the rest with the sign bit or zero.
  function automatic logic [BIT_COUNT-1:0] extend_value(
    input logic [BIT_COUNT-1:0] raw,
    input logic [3:0]           size,
    input logic                 sgn
  );
    logic [BIT_COUNT-1:0] out;
    logic [7:0]           nb;
    logic [IW-1:0]        top;
    logic                 fill;
    nb   = {1'b0, size, 3'b000};
    top  = IW'(nb - 8'd1);
    fill = sgn & raw[top];
    out  = '0;
    for (int i = 0; i < BIT_COUNT; i++) begin
      out[i] = (i < int'(nb)) ? raw[i] : fill;
    end
    return out;
  endfunction

  // Decode the requested mode into access size, legality and signedness.
  always_comb begin
    w_size   = 4'd0;
    w_legal  = 1'b1;
    w_signed = (ld_mode <= 3'd2);
    case (ld_mode)
      3'd0, 3'd3: w_size = 4'd1;
      3'd1, 3'd4: w_size = 4'd2;
      3'd2, 3'd5: w_size = 4'd4;
      3'd6:       w_size = 4'd8;
      default:    w_size = 4'd0;
    endcase
    if (ld_mode == 3'd7) begin
      w_legal = 1'b0;
    end else if ((ld_mode == 3'd5 || ld_mode == 3'd6) && BYTES < 8) begin
      w_legal = 1'b0;
    end
    w_span  = 5'(ld_addr[OFS-1:0]) + {1'b0, w_size};
    w_split = (w_span > 5'(BYTES));
  end

  // Next-state logic and the per-cycle control strobes.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_fault      = 1'b0;
    w_cap_lo     = 1'b0;
    w_to_beat2   = 1'b0;
    w_to_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ld_valid) begin
          if (w_legal) begin
            w_accept     = 1'b1;
            w_state_next = S_BEAT1;
          end else begin
            w_fault = 1'b1;
          end
        end
      end
      S_BEAT1: begin
        if (mem_ack) begin
          w_cap_lo = 1'b1;
          if (r_split) begin
            w_to_beat2   = 1'b1;
            w_state_next = S_BEAT2;
          end else begin
            w_to_done    = 1'b1;
            w_state_next = S_DONE;
          end
        end
      end
      S_BEAT2: begin
        if (mem_ack) begin
          w_to_done    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Merge the beats (upper half is zero for a single-beat load), shift the
  // addressed byte down to bit 0 and extend.
  always_comb begin
    if (r_state == S_BEAT2) begin
      w_merged = {mem_rdata, r_lo};
    end else begin
      w_merged = {{BIT_COUNT{1'b0}}, mem_rdata};
    end
    w_raw    = BIT_COUNT'(w_merged >> {r_ofs, 3'b000});
    w_result = extend_value(w_raw, r_size, r_signed);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request latch, beat address, first-beat capture, result and fault pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_addr <= '0;
      r_ofs      <= '0;
      r_size     <= '0;
      r_signed   <= 1'b0;
      r_split    <= 1'b0;
      r_lo       <= '0;
      r_result   <= '0;
      r_fault    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem_addr <= {ld_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
        r_ofs      <= ld_addr[OFS-1:0];
        r_size     <= w_size;
        r_signed   <= w_signed;
        r_split    <= w_split;
      end
      if (w_to_beat2) begin
        r_mem_addr <= r_mem_addr + ADDR_W'(BYTES);
      end
      if (w_cap_lo) begin
        r_lo <= mem_rdata;
      end
      if (w_to_done) begin
        r_result <= w_result;
      end
      r_fault <= w_fault;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign mem_req   = (r_state == S_BEAT1) || (r_state == S_BEAT2);
  assign mem_addr  = r_mem_addr;
  assign ld_done   = (r_state == S_DONE);
  assign ld_result = r_result;
  assign ld_fault  = r_fault;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_load_align_sequencer.sv
// Directed bench for load_align_sequencer: a 32-bit instance covers
// split/unsplit loads, ack wait states, faults, address wrap and reset abort;
// a 64-bit instance covers WORD/WORD_U/DOUBLE sizing.
module tb_load_align_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        reset;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_mode;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ld_done;
  logic [31:0] ld_result;
  logic        ld_fault;
  logic [1:0]  dbg_state;

  // 64-bit instance signals
  logic        w_ld_valid;
  logic [31:0] w_ld_addr;
  logic [2:0]  w_ld_mode;
  logic        w_busy;
  logic        w_mem_req;
  logic [31:0] w_mem_addr;
  logic        w_mem_ack;
  logic [63:0] w_mem_rdata;
  logic        w_ld_done;
  logic [63:0] w_ld_result;
  logic        w_ld_fault;
  logic [1:0]  w_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int hs      = 0;
  int h0      = 0;

  load_align_sequencer #(.BIT_COUNT(32), .ADDR_W(32)) dut32 (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_mode(ld_mode), .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ld_done(ld_done),
    .ld_result(ld_result), .ld_fault(ld_fault), .dbg_state(dbg_state)
  );

  load_align_sequencer #(.BIT_COUNT(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset), .ld_valid(w_ld_valid), .ld_addr(w_ld_addr),
    .ld_mode(w_ld_mode), .busy(w_busy), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata), .ld_done(w_ld_done),
    .ld_result(w_ld_result), .ld_fault(w_ld_fault), .dbg_state(w_dbg_state)
  );

  // Count memory handshakes of the 32-bit instance.
  always @(posedge clk) begin
    if (mem_req && mem_ack) hs <= hs + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a legal load for one cycle; afterwards we are in BEAT1.
  task automatic accept(input string tag, input logic [2:0] mode, input logic [31:0] addr);
    ld_valid = 1'b1;
    ld_mode  = mode;
    ld_addr  = addr;
    step();
    ld_valid = 1'b0;
    check({tag, " busy after accept"}, 64'(busy), 64'd1);
    check({tag, " req after accept"}, 64'(mem_req), 64'd1);
  endtask

  // Hold off mem_ack for 'delay' cycles, then acknowledge one beat.
  task automatic serve(input string tag, input logic [31:0] exp_addr,
                       input logic [31:0] data, input int delay);
    for (int k = 0; k < delay; k++) begin
      check({tag, " wait req"}, 64'(mem_req), 64'd1);
      check({tag, " wait addr"}, 64'(mem_addr), 64'(exp_addr));
      check({tag, " wait busy"}, 64'(busy), 64'd1);
      check({tag, " wait done"}, 64'(ld_done), 64'd0);
      step();
    end
    check({tag, " beat addr"}, 64'(mem_addr), 64'(exp_addr));
    check({tag, " beat done"}, 64'(ld_done), 64'd0);
    mem_ack   = 1'b1;
    mem_rdata = data;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  // In the DONE cycle: result present, then everything returns to idle.
  task automatic finish_load(input string tag, input logic [31:0] exp);
    check({tag, " done"}, 64'(ld_done), 64'd1);
    check({tag, " result"}, 64'(ld_result), 64'(exp));
    check({tag, " busy at done"}, 64'(busy), 64'd1);
    check({tag, " req at done"}, 64'(mem_req), 64'd0);
    step();
    check({tag, " done drops"}, 64'(ld_done), 64'd0);
    check({tag, " busy drops"}, 64'(busy), 64'd0);
    check({tag, " result held"}, 64'(ld_result), 64'(exp));
  endtask

  // One load on the 64-bit instance with immediate acks.
  task automatic w_load(input string tag, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] a0, input logic [63:0] d0, input logic two,
                        input logic [31:0] a1, input logic [63:0] d1, input logic [63:0] exp);
    w_ld_valid = 1'b1;
    w_ld_mode  = mode;
    w_ld_addr  = addr;
    step();
    w_ld_valid = 1'b0;
    check({tag, " req"}, 64'(w_mem_req), 64'd1);
    check({tag, " addr0"}, 64'(w_mem_addr), 64'(a0));
    w_mem_ack   = 1'b1;
    w_mem_rdata = d0;
    step();
    if (two) begin
      check({tag, " addr1"}, 64'(w_mem_addr), 64'(a1));
      check({tag, " req beat2"}, 64'(w_mem_req), 64'd1);
      w_mem_rdata = d1;
      step();
    end
    w_mem_ack   = 1'b0;
    w_mem_rdata = '0;
    check({tag, " done"}, 64'(w_ld_done), 64'd1);
    check({tag, " result"}, w_ld_result, exp);
    step();
    check({tag, " idle"}, 64'(w_busy), 64'd0);
  endtask

  logic [2:0] bad_modes [3];

  initial begin
    reset       = 1'b1;
    ld_valid    = 1'b0;
    ld_addr     = '0;
    ld_mode     = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    w_ld_valid  = 1'b0;
    w_ld_addr   = '0;
    w_ld_mode   = '0;
    w_mem_ack   = 1'b0;
    w_mem_rdata = '0;
    bad_modes[0] = 3'd6;
    bad_modes[1] = 3'd7;
    bad_modes[2] = 3'd5;

    // Reset state
    step(); step(); step();
    reset = 1'b0;
    step();
    check("rst busy", 64'(busy), 64'd0);
    check("rst req", 64'(mem_req), 64'd0);
    check("rst addr", 64'(mem_addr), 64'd0);
    check("rst done", 64'(ld_done), 64'd0);
    check("rst fault", 64'(ld_fault), 64'd0);
    check("rst result", 64'(ld_result), 64'd0);
    check("rst state", 64'(dbg_state), 64'd0);
    check("rst w busy", 64'(w_busy), 64'd0);

    // BYTE at 0x1003, single beat; ld_done in the third cycle counting accept
    h0 = hs;
    accept("t1", 3'd0, 32'h0000_1003);
    serve("t1", 32'h0000_1000, 32'h80FF_0000, 0);
    finish_load("t1", 32'hFFFF_FF80);
    check("t1 handshakes", 64'(hs - h0), 64'd1);

    // HALF_U at 0x1003 splits into two beats
    h0 = hs;
    accept("t2", 3'd4, 32'h0000_1003);
    serve("t2a", 32'h0000_1000, 32'hAB00_0000, 0);
    check("t2 state beat2", 64'(dbg_state), 64'd2);
    check("t2 req beat2", 64'(mem_req), 64'd1);
    serve("t2b", 32'h0000_1004, 32'h0000_00CD, 0);
    finish_load("t2", 32'h0000_CDAB);
    check("t2 handshakes", 64'(hs - h0), 64'd2);

    // WORD at 0x1002, each beat acked after 3 wait cycles
    accept("t3", 3'd2, 32'h0000_1002);
    serve("t3a", 32'h0000_1000, 32'h1234_5678, 3);
    serve("t3b", 32'h0000_1004, 32'h9ABC_DEF0, 3);
    finish_load("t3", 32'hDEF0_1234);

    // Illegal modes at XLEN=32: fault pulse, no memory traffic
    h0 = hs;
    for (int m = 0; m < 3; m++) begin
      ld_valid = 1'b1;
      ld_mode  = bad_modes[m];
      ld_addr  = 32'h0000_3000;
      step();
      ld_valid = 1'b0;
      check("t4 fault pulse", 64'(ld_fault), 64'd1);
      check("t4 busy", 64'(busy), 64'd0);
      check("t4 req", 64'(mem_req), 64'd0);
      check("t4 state", 64'(dbg_state), 64'd0);
      step();
      check("t4 fault drops", 64'(ld_fault), 64'd0);
      check("t4 req after", 64'(mem_req), 64'd0);
    end
    check("t4 no handshakes", 64'(hs - h0), 64'd0);
    accept("t4u", 3'd3, 32'h0000_2000);
    serve("t4u", 32'h0000_2000, 32'h0000_00F0, 0);
    finish_load("t4u", 32'h0000_00F0);

    // Signed HALF ending exactly at the boundary: one beat
    h0 = hs;
    accept("t5", 3'd1, 32'h0000_1002);
    serve("t5", 32'h0000_1000, 32'h8001_0000, 0);
    finish_load("t5", 32'hFFFF_8001);
    check("t5 handshakes", 64'(hs - h0), 64'd1);

    // Split WORD at the top of the address space: second beat wraps to 0
    accept("t6", 3'd2, 32'hFFFF_FFFE);
    serve("t6a", 32'hFFFF_FFFC, 32'hBBAA_0000, 1);
    serve("t6b", 32'h0000_0000, 32'h0000_DDCC, 0);
    finish_load("t6", 32'hDDCC_BBAA);

    // Reset while waiting for the second beat
    accept("t7", 3'd1, 32'h0000_1003);
    serve("t7a", 32'h0000_1000, 32'h1100_0000, 0);
    check("t7 in beat2", 64'(dbg_state), 64'd2);
    reset = 1'b1;
    #1;
    check("t7 req async", 64'(mem_req), 64'd0);
    check("t7 busy async", 64'(busy), 64'd0);
    check("t7 state async", 64'(dbg_state), 64'd0);
    check("t7 done async", 64'(ld_done), 64'd0);
    step();
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0022;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("t7 stray ack done", 64'(ld_done), 64'd0);
    check("t7 stray ack state", 64'(dbg_state), 64'd0);
    check("t7 stray ack req", 64'(mem_req), 64'd0);
    check("t7 result cleared", 64'(ld_result), 64'd0);
    step();
    check("t7 still no done", 64'(ld_done), 64'd0);
    accept("t7n", 3'd2, 32'h0000_1000);
    serve("t7n", 32'h0000_1000, 32'h1122_3344, 0);
    finish_load("t7n", 32'h1122_3344);

    // XLEN=64 sizing
    w_load("w1", 3'd2, 32'h0000_000C, 32'h0000_0008, 64'h8000_0000_0000_0000,
           1'b0, 32'h0, 64'h0, 64'hFFFF_FFFF_8000_0000);
    w_load("w2", 3'd5, 32'h0000_000C, 32'h0000_0008, 64'h8000_0000_0000_0000,
           1'b0, 32'h0, 64'h0, 64'h0000_0000_8000_0000);
    w_load("w3", 3'd6, 32'h0000_0010, 32'h0000_0010, 64'h8123_4567_89AB_CDEF,
           1'b0, 32'h0, 64'h0, 64'h8123_4567_89AB_CDEF);
    w_load("w4", 3'd6, 32'h0000_000C, 32'h0000_0008, 64'h1122_3344_5566_7788,
           1'b1, 32'h0000_0010, 64'h99AA_BBCC_DDEE_FF00, 64'hDDEE_FF00_1122_3344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
